// File: rtl/bist_sequencer.sv
// BIST phase controller: steps ring/Johnson/LFSR generators and compresses data_in into a MISR.
// Latency: outputs registered; the first phase is active the cycle after an accepted start.
// Backpressure: none; start is ignored while busy, and abort always wins.
module bist_sequencer #(
    parameter int                 WIDTH          = 16,
    parameter int                 CNT_W          = 16,
    parameter int                 RING_CYCLES    = 16,
    parameter int                 JOHNSON_CYCLES = 32,
    parameter int                 LFSR_CYCLES    = 255,
    parameter logic [WIDTH-1:0]   GOLDEN         = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       phase_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [1:0]       mode,
    output logic             ring_en,
    output logic             johnson_en,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_RING, S_JOHNSON, S_LFSR, S_DONE} state_t;

    localparam logic [CNT_W-1:0] RING_LAST    = CNT_W'(RING_CYCLES - 1);
    localparam logic [CNT_W-1:0] JOHNSON_LAST = CNT_W'(JOHNSON_CYCLES - 1);
    localparam logic [CNT_W-1:0] LFSR_LAST    = CNT_W'(LFSR_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       phase_q;
    logic [WIDTH-1:0] sig_nxt;
    logic             last_cycle;

    // First enabled phase strictly after cur; S_IDLE means "from the beginning".
    function automatic state_t next_phase(input logic [2:0] en, input state_t cur);
        state_t nxt;
        nxt = S_DONE;
        if (en[2] && cur != S_LFSR) nxt = S_LFSR;
        if (en[1] && (cur == S_IDLE || cur == S_RING)) nxt = S_JOHNSON;
        if (en[0] && cur == S_IDLE) nxt = S_RING;
        return nxt;
    endfunction

    always_comb begin
        sig_nxt = {signature[WIDTH-2:0],
                   signature[WIDTH-1] ^ signature[WIDTH-3] ^ signature[WIDTH-4] ^ signature[WIDTH-6]}
                  ^ data_in;
        case (state)
            S_RING:    last_cycle = (cycle_cnt == RING_LAST);
            S_JOHNSON: last_cycle = (cycle_cnt == JOHNSON_LAST);
            S_LFSR:    last_cycle = (cycle_cnt == LFSR_LAST);
            default:   last_cycle = 1'b0;
        endcase

        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_nxt = next_phase(phase_en, S_IDLE);
                S_RING, S_JOHNSON, S_LFSR: if (last_cycle) state_nxt = next_phase(phase_q, state);
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase_q    <= '0;
            mode       <= 2'b00;
            ring_en    <= 1'b0;
            johnson_en <= 1'b0;
            lfsr_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= '0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            // Output decode follows the next state so every output is a flop.
            mode       <= 2'b00;
            ring_en    <= 1'b0;
            johnson_en <= 1'b0;
            lfsr_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            case (state_nxt)
                S_RING:    begin mode <= 2'b01; ring_en    <= 1'b1; busy <= 1'b1; end
                S_JOHNSON: begin mode <= 2'b10; johnson_en <= 1'b1; busy <= 1'b1; end
                S_LFSR:    begin mode <= 2'b11; lfsr_en    <= 1'b1; busy <= 1'b1; end
                S_DONE:    done <= 1'b1;
                default:   ;
            endcase

            if (abort) begin
                pass      <= 1'b0;
                signature <= '0;
                cycle_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            phase_q   <= phase_en;
                            signature <= '0;
                            cycle_cnt <= '0;
                            pass      <= (state_nxt == S_DONE) && (GOLDEN == '0);
                        end
                    end
                    S_RING, S_JOHNSON, S_LFSR: begin
                        signature <= sig_nxt;
                        cycle_cnt <= last_cycle ? '0 : cycle_cnt + CNT_W'(1);
                        if (state_nxt == S_DONE) pass <= (sig_nxt == GOLDEN);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Controller that sequences the BIST pattern datapath (ring counter, Johnson counter, LFSR behind a 2-bit mode mux) through its three pattern phases automatically.
- Per phase, drives the mode select and exactly one generator enable for a programmed number of cycles.
- Compresses the observed 16-bit pattern into a MISR signature and reports pass/fail against a golden value.
- Sits between the top-level test control (start/abort) and the datapath's mode/enable inputs.

Parameters:
- WIDTH, 16, width of the observed pattern bus and the signature.
- CNT_W, 16, width of the phase cycle counter.
- RING_CYCLES, 16, cycles spent in the ring phase (1..2^CNT_W-1).
- JOHNSON_CYCLES, 32, cycles spent in the Johnson phase (same range).
- LFSR_CYCLES, 255, cycles spent in the LFSR phase (same range).
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- abort  in  1  level; forces return to IDLE.
- phase_en  in  3  phase enables {lfsr, johnson, ring}, sampled on accepted start.
- data_in  in  WIDTH  pattern observed from the datapath's led output.
- mode  out  2  datapath mode select: 00 idle, 01 ring, 10 Johnson, 11 LFSR.
- ring_en  out  1  ring counter enable.
- johnson_en  out  1  Johnson counter enable.
- lfsr_en  out  1  LFSR enable.
- busy  out  1  high in any run phase.
- done  out  1  high in DONE.
- pass  out  1  signature==GOLDEN; valid only while done=1.
- signature  out  WIDTH  current MISR contents.
- cycle_cnt  out  CNT_W  cycles elapsed in the current phase.

Behaviour:
- Reset: state=IDLE; mode=00, all enables 0, busy=0, done=0, pass=0, signature=0, cycle_cnt=0. All outputs registered.
- States: IDLE, RING, JOHNSON, LFSR, DONE.
  - State RING drives mode=01, ring_en=1.
  - State JOHNSON drives mode=10, johnson_en=1.
  - State LFSR drives mode=11, lfsr_en=1.
  - At most one enable is high in any cycle. IDLE and DONE drive mode=00 with all enables 0.
- Start in IDLE or DONE:
  - Latch phase_en and clear signature and cycle_cnt.
  - Next state is the first enabled phase, in order RING, JOHNSON, LFSR.
  - If phase_en=000, go straight to DONE; pass=(0==GOLDEN).
- Start while busy is ignored.
- In a phase:
  - Each cycle: signature <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ data_in (polynomial x^16+x^14+x^13+x^11+1). For WIDTH≠16 this polynomial is not defined; WIDTH=16 is the supported configuration.
  - Each cycle: cycle_cnt increments.
  - When cycle_cnt==PHASE_CYCLES-1, the next state is the next enabled phase (cycle_cnt reset to 0), or DONE if none remain.
  - Phase length is exactly PHASE_CYCLES clocks. Adjacent phases have no gap cycle.
- DONE:
  - done=1, busy=0.
  - pass registered on entry from the final signature; signature held.
  - Remains in DONE until start, abort or rst.
- Abort (any state): next state IDLE, all outputs return to reset values. abort has priority over start in the same cycle.
- rst mid-run: identical to abort, plus phase_en latch cleared.
- cycle_cnt never wraps: phase exits at PHASE_CYCLES-1 < 2^CNT_W.
- data_in sampled on the same edge the state is active. Alignment to generator latency is the datapath's responsibility.

Test Plan:
- Reset, then idle 5 cycles -> mode=00, enables 0, busy=0, done=0, signature=0.
- phase_en=111, start, data_in=16'h0001 constant:
  - busy for exactly 16+32+255=303 cycles.
  - mode follows 01 (16 cycles), then 10 (32), then 11 (255).
  - done rises on cycle 304.
  - signature matches reference MISR model.
  - pass=1 when GOLDEN is set to that value, 0 otherwise.
- phase_en=101, start -> ring 16 cycles directly followed by LFSR 255 cycles. johnson_en never asserts. Total busy 271 cycles.
- Abort asserted at cycle 20 (Johnson phase) together with start -> IDLE next cycle, all outputs zero. A later start runs the full sequence again.
- phase_en=000, start -> DONE next cycle with signature=0. pass=1 iff GOLDEN=0.
- Start pulsed during LFSR phase -> ignored, sequence length unchanged. Start in DONE -> signature cleared and a new run begins.
